// File: rtl/ddr_a2m_pkg.sv
// Shared encodings for the AXI-to-MBA burst address sequencer.
package ddr_a2m_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [2:0] {
    SZ1   = 3'd0,
    SZ2   = 3'd1,
    SZ4   = 3'd2,
    SZ8   = 3'd3,
    SZ16  = 3'd4,
    SZ32  = 3'd5,
    SZ64  = 3'd6,
    SZ128 = 3'd7
  } size_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam int PAGE_SIZE = 4096;

  // Only LEN values 1/3/7/15 ever reach this, so a priority pick is exact.
  function automatic logic [3:0] wrap_log2(input logic [7:0] len);
    if (len[3])      return 4'd4;
    else if (len[2]) return 4'd3;
    else if (len[1]) return 4'd2;
    else if (len[0]) return 4'd1;
    else             return 4'd0;
  endfunction

endpackage

// File: rtl/ddr_a2m_beat_addr_calc.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module ddr_a2m_beat_addr_calc
  import ddr_a2m_pkg::*;
#(
  parameter int P_AW = 32
) (
  input  logic [P_AW-1:0] addr,
  input  logic [2:0]      size,
  input  logic [7:0]      len,
  input  logic [1:0]      burst,
  output logic [P_AW-1:0] next_addr
);

  logic [P_AW-1:0] sz;
  logic [P_AW-1:0] aligned;
  logic [P_AW-1:0] wrap_w;
  logic [7:0]      wrap_bits;

  // Wrap bits cover the burst's byte span; everything above bit 7 is held.
  always_comb begin
    sz        = P_AW'(1) << size;
    aligned   = addr & ({P_AW{1'b1}} << size);
    wrap_bits = ~(8'hFF << ({1'b0, size} + wrap_log2(len)));
    wrap_w    = P_AW'(wrap_bits);
    case (burst)
      BURST_INCR: next_addr = aligned + sz;
      BURST_WRAP: next_addr = (addr & ~wrap_w) | ((addr + sz) & wrap_w);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/ddr_a2m_burst_seq.sv
// Burst address sequencer: one AXI command in, one MBA beat address per handshake out.
// Optional DDR_A2M_BSEQ_UNALIGN_EN: INCR/FIXED beat 0 keeps the raw unaligned start address.
module ddr_a2m_burst_seq
  import ddr_a2m_pkg::*;
#(
  parameter int P_AW    = 32,
  parameter int P_IDW   = 4,
  parameter int P_MAXSZ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [P_AW-1:0]  s_addr,
  input  logic [7:0]       s_len,
  input  logic [2:0]       s_size,
  input  logic [1:0]       s_burst,
  input  logic [P_IDW-1:0] s_id,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [P_AW-1:0]  b_addr,
  output logic             b_last,
  output logic [7:0]       b_beat,
  output logic [P_IDW-1:0] b_id,
  output logic             b_err
);

  logic [0:0]      state;
  logic [2:0]      cur_size;
  logic [7:0]      cur_len;
  logic [1:0]      cur_burst;
  logic [P_AW-1:0] next_addr;
  logic [P_AW-1:0] start_addr;
  logic [P_AW-1:0] s_aligned;
  logic [16:0]     page_end;
  logic [1:0]      eff_burst;
  logic            size_bad, burst_rsvd, wrap_len_ok, wrap_unal, page_cross;
  logic            cmd_err, accept, beat_fire;

  assign beat_fire = b_valid & b_ready;
  assign s_ready   = (state == ST_IDLE) | (beat_fire & b_last);
  assign accept    = s_valid & s_ready;

  // Illegal commands are demoted to a safe burst type so all LEN+1 beats still drain.
  always_comb begin
    s_aligned   = s_addr & ({P_AW{1'b1}} << s_size);
    size_bad    = s_size > 3'(P_MAXSZ);
    burst_rsvd  = s_burst == BURST_RSVD;
    wrap_len_ok = (s_len == 8'd1) || (s_len == 8'd3) || (s_len == 8'd7) || (s_len == 8'd15);
    wrap_unal   = s_aligned != s_addr;
    page_end    = 17'(s_addr[11:0]) + ((17'(s_len) + 17'd1) << s_size);
    page_cross  = page_end > 17'(PAGE_SIZE);
    eff_burst   = s_burst;
    cmd_err     = 1'b0;
    if (size_bad || burst_rsvd) begin
      eff_burst = BURST_FIXED;
      cmd_err   = 1'b1;
    end else if ((s_burst == BURST_WRAP) && (!wrap_len_ok || wrap_unal)) begin
      eff_burst = BURST_INCR;
      cmd_err   = 1'b1;
    end else if ((s_burst == BURST_INCR) && page_cross) begin
      cmd_err   = 1'b1;
    end
`ifdef DDR_A2M_BSEQ_UNALIGN_EN
    start_addr = s_addr;
`else
    start_addr = (eff_burst == BURST_WRAP) ? s_addr : s_aligned;
`endif
  end

  ddr_a2m_beat_addr_calc #(
    .P_AW(P_AW)
  ) u_addr_calc (
    .addr     (b_addr),
    .size     (cur_size),
    .len      (cur_len),
    .burst    (cur_burst),
    .next_addr(next_addr)
  );

  // A new command wins over retiring the last beat, giving zero-bubble bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      b_valid   <= 1'b0;
      b_addr    <= '0;
      b_last    <= 1'b0;
      b_beat    <= 8'd0;
      b_id      <= '0;
      b_err     <= 1'b0;
      cur_size  <= 3'd0;
      cur_len   <= 8'd0;
      cur_burst <= BURST_FIXED;
    end else if (accept) begin
      state     <= ST_BURST;
      b_valid   <= 1'b1;
      b_addr    <= start_addr;
      b_last    <= (s_len == 8'd0);
      b_beat    <= 8'd0;
      b_id      <= s_id;
      b_err     <= cmd_err;
      cur_size  <= s_size;
      cur_len   <= s_len;
      cur_burst <= eff_burst;
    end else if (beat_fire) begin
      if (b_last) begin
        state   <= ST_IDLE;
        b_valid <= 1'b0;
      end else begin
        b_beat  <= b_beat + 8'd1;
        b_addr  <= next_addr;
        b_last  <= ((b_beat + 8'd1) == cur_len);
      end
    end
  end

endmodule

// File: tb/tb_ddr_a2m_burst_seq.sv
// Self-checking bench for ddr_a2m_burst_seq: vector table plus scoreboard of expected beats.
`timescale 1ns/1ps
module tb_ddr_a2m_burst_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_addr = '0;
  logic [7:0]  s_len = '0;
  logic [2:0]  s_size = '0;
  logic [1:0]  s_burst = '0;
  logic [3:0]  s_id = '0;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [31:0] b_addr;
  logic        b_last;
  logic [7:0]  b_beat;
  logic [3:0]  b_id;
  logic        b_err;

  always #5 clk = ~clk;

  ddr_a2m_burst_seq #(
    .P_AW(32), .P_IDW(4), .P_MAXSZ(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_len(s_len),
    .s_size(s_size), .s_burst(s_burst), .s_id(s_id),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_last(b_last),
    .b_beat(b_beat), .b_id(b_id), .b_err(b_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic        err;
    logic [31:0] exp0, exp1, exp2, exp3;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        last;
    logic [7:0]  beat;
    logic [3:0]  id;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vecs[14];
  int    checks = 0;
  int    errors = 0;
  logic  rand_bp = 1'b0;

  function automatic logic [31:0] expAddr(input vec_t v, input int i);
    case (i)
      0:       return v.exp0;
      1:       return v.exp1;
      2:       return v.exp2;
      default: return v.exp3;
    endcase
  endfunction

  task automatic pushBurst(input vec_t v);
    for (int i = 0; i <= int'(v.len); i++) begin
      beat_t e;
      e.addr = expAddr(v, i);
      e.last = (i == int'(v.len));
      e.beat = 8'(i);
      e.id   = v.id;
      e.err  = v.err;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkOutput();
    beat_t got, e;
    got = {b_addr, b_last, b_beat, b_id, b_err};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL beat_unexpected: got addr=%h last=%b beat=%0d id=%0d err=%b, want no beat",
               b_addr, b_last, b_beat, b_id, b_err);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("[TB] FAIL beat: got addr=%h last=%b beat=%0d id=%0d err=%b, want addr=%h last=%b beat=%0d id=%0d err=%b",
                 b_addr, b_last, b_beat, b_id, b_err, e.addr, e.last, e.beat, e.id, e.err);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) checkOutput();
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) b_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drive a command and hold it until accepted; returns 1ns after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit do_push);
    bit done;
    done    = 1'b0;
    s_addr  = v.addr;
    s_len   = v.len;
    s_size  = v.size;
    s_burst = v.burst;
    s_id    = v.id;
    s_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (s_ready) begin
        if (do_push) pushBurst(v);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL cmd_accept: s_ready got 0, want 1 within 200 cycles");
    end
    s_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !b_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d beats still expected, want 0", exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t v;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_b_valid", 64'(b_valid), 64'd0);
    checkVal("rst_b_last",  64'(b_last),  64'd0);
    checkVal("rst_b_err",   64'(b_err),   64'd0);
    checkVal("rst_b_beat",  64'(b_beat),  64'd0);
    checkVal("rst_b_addr",  64'(b_addr),  64'd0);
    checkVal("rst_b_id",    64'(b_id),    64'd0);
    checkVal("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs[0]  = '{32'h1000, 8'd3, 3'd2, 2'b01, 4'd1,  1'b0, 32'h1000, 32'h1004, 32'h1008, 32'h100C};
    vecs[1]  = '{32'h1034, 8'd3, 3'd2, 2'b10, 4'd2,  1'b0, 32'h1034, 32'h1038, 32'h103C, 32'h1030};
    vecs[2]  = '{32'h1034, 8'd2, 3'd2, 2'b10, 4'd3,  1'b1, 32'h1034, 32'h1038, 32'h103C, 32'h0};
    vecs[3]  = '{32'h2000, 8'd2, 3'd5, 2'b01, 4'd4,  1'b1, 32'h2000, 32'h2000, 32'h2000, 32'h0};
    vecs[4]  = '{32'h0FF8, 8'd1, 3'd3, 2'b01, 4'd5,  1'b1, 32'h0FF8, 32'h1000, 32'h0, 32'h0};
`ifdef DDR_A2M_BSEQ_UNALIGN_EN
    vecs[5]  = '{32'h1003, 8'd1, 3'd2, 2'b01, 4'd6,  1'b0, 32'h1003, 32'h1004, 32'h0, 32'h0};
    vecs[8]  = '{32'h1036, 8'd3, 3'd2, 2'b10, 4'd9,  1'b1, 32'h1036, 32'h1038, 32'h103C, 32'h1040};
`else
    vecs[5]  = '{32'h1003, 8'd1, 3'd2, 2'b01, 4'd6,  1'b0, 32'h1000, 32'h1004, 32'h0, 32'h0};
    vecs[8]  = '{32'h1036, 8'd3, 3'd2, 2'b10, 4'd9,  1'b1, 32'h1034, 32'h1038, 32'h103C, 32'h1040};
`endif
    vecs[6]  = '{32'h3004, 8'd3, 3'd2, 2'b00, 4'd7,  1'b0, 32'h3004, 32'h3004, 32'h3004, 32'h3004};
    vecs[7]  = '{32'h4000, 8'd1, 3'd2, 2'b11, 4'd8,  1'b1, 32'h4000, 32'h4000, 32'h0, 32'h0};
    vecs[9]  = '{32'h5008, 8'd0, 3'd3, 2'b01, 4'd10, 1'b0, 32'h5008, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{32'h1008, 8'd1, 3'd3, 2'b10, 4'd11, 1'b0, 32'h1008, 32'h1000, 32'h0, 32'h0};
    vecs[11] = '{32'hFFF0, 8'd3, 3'd2, 2'b01, 4'd12, 1'b0, 32'hFFF0, 32'hFFF4, 32'hFFF8, 32'hFFFC};
    vecs[12] = '{32'h3000, 8'd0, 3'd0, 2'b00, 4'd13, 1'b0, 32'h3000, 32'h0, 32'h0, 32'h0};
    vecs[13] = '{32'h6000, 8'd0, 3'd2, 2'b10, 4'd14, 1'b1, 32'h6000, 32'h0, 32'h0, 32'h0};

    $display("[TB] vector table with random backpressure");
    rand_bp = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], 1'b1);
    waitDrain();
    rand_bp = 1'b0;
    b_ready = 1'b1;

    $display("[TB] 16-beat WRAP across 256-byte boundary");
    for (int i = 0; i < 16; i++) begin
      beat_t e;
      e.addr = 32'h2000 | ((32'hF0 + 32'(16 * i)) & 32'hFF);
      e.last = (i == 15);
      e.beat = 8'(i);
      e.id   = 4'd15;
      e.err  = 1'b0;
      exp_q.push_back(e);
    end
    v = '{32'h20F0, 8'd15, 3'd4, 2'b10, 4'd15, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    applyStimulus(v, 1'b0);
    waitDrain();

    $display("[TB] backpressure hold mid-burst");
    b_ready = 1'b0;
    applyStimulus(vecs[0], 1'b1);
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    b_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("hold_beat1", {b_valid, b_addr, b_beat, b_last}, {1'b1, 32'h1004, 8'd1, 1'b0});
      @(posedge clk);
      #1;
    end
    b_ready = 1'b1;
    waitDrain();

    $display("[TB] back-to-back single-beat bursts");
    v = '{32'h6000, 8'd0, 3'd2, 2'b01, 4'd1, 1'b0, 32'h6000, 32'h0, 32'h0, 32'h0};
    s_addr = v.addr; s_len = v.len; s_size = v.size; s_burst = v.burst; s_id = v.id;
    s_valid = 1'b1;
    pushBurst(v);
    @(posedge clk);
    #1;
    v = '{32'h7000, 8'd0, 3'd2, 2'b01, 4'd2, 1'b0, 32'h7000, 32'h0, 32'h0, 32'h0};
    s_addr = v.addr; s_id = v.id;
    @(negedge clk);
    checkVal("b2b_sready_on_last", {s_ready, b_valid, b_last}, {1'b1, 1'b1, 1'b1});
    pushBurst(v);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkVal("b2b_second_beat", {b_valid, b_addr, b_id}, {1'b1, 32'h7000, 4'd2});
    waitDrain();

    $display("[TB] reset mid-burst");
    v = '{32'h8000, 8'd7, 3'd2, 2'b01, 4'd5, 1'b0, 32'h8000, 32'h8004, 32'h8008, 32'h800C};
    applyStimulus(v, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkVal("rst_mid_burst", {b_valid, s_ready, b_beat, b_last, b_addr},
             {1'b0, 1'b1, 8'd0, 1'b0, 32'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '{32'h9000, 8'd0, 3'd2, 2'b00, 4'd6, 1'b0, 32'h9000, 32'h0, 32'h0, 32'h0};
    applyStimulus(v, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
